// File: rtl/locking_router_0_pkg.sv
// locking_router_0_pkg
//   Shared definitions for the Release-channel locking router: Release type
//   encodings, the lock state type, the Release beat layout (default widths)
//   and the has_data classification used to decide whether a beat opens a
//   multi-beat burst.
//   No ports. Optional checker macro used elsewhere: LOCKING_ROUTER_BEAT_CHECK_EN.
package locking_router_0_pkg;

  localparam int N_BEATS_DEF      = 4;
  localparam int DATA_W_DEF       = 128;
  localparam int ADDR_BLOCK_W     = 26;
  localparam int CLIENT_XACT_ID_W = 6;
  localparam int R_TYPE_W         = 3;

  typedef enum logic [R_TYPE_W-1:0] {
    REL_INVALIDATE_DATA = 3'd0,
    REL_DOWNGRADE_DATA  = 3'd1,
    REL_COPY_DATA       = 3'd2,
    REL_INVALIDATE_ACK  = 3'd3,
    REL_DOWNGRADE_ACK   = 3'd4,
    REL_COPY_ACK        = 3'd5
  } release_type_e;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic [$clog2(N_BEATS_DEF)-1:0] addr_beat;
    logic [ADDR_BLOCK_W-1:0]        addr_block;
    logic [CLIENT_XACT_ID_W-1:0]    client_xact_id;
    logic                           voluntary;
    logic [R_TYPE_W-1:0]            r_type;
    logic [DATA_W_DEF-1:0]          data;
  } release_beat_t;

  // Only the three *Data Release types carry a full N_BEATS payload.
  function automatic logic has_data(input logic [R_TYPE_W-1:0] r_type);
    return (r_type == REL_INVALIDATE_DATA) ||
           (r_type == REL_DOWNGRADE_DATA)  ||
           (r_type == REL_COPY_DATA);
  endfunction

endpackage

// File: rtl/locking_router_0_if.sv
// locking_router_0_if
//   Bundle of the upstream Release beat stream, the steering select, the two
//   downstream Release outputs and the status outputs.
//   Modports:
//     master - upstream producer / downstream consumers side (drives in_*, sel,
//              out_k_ready)
//     slave  - the router itself
//   io_beat_err is only meaningful when LOCKING_ROUTER_BEAT_CHECK_EN is defined.
interface locking_router_0_if #(
  parameter int N_BEATS = 4,
  parameter int DATA_W  = 128
);
  localparam int BW = $clog2(N_BEATS);

  logic              io_in_valid;
  logic              io_in_ready;
  logic [BW-1:0]     io_in_bits_addr_beat;
  logic [25:0]       io_in_bits_addr_block;
  logic [5:0]        io_in_bits_client_xact_id;
  logic              io_in_bits_voluntary;
  logic [2:0]        io_in_bits_r_type;
  logic [DATA_W-1:0] io_in_bits_data;
  logic              io_sel;

  logic              io_out_0_valid;
  logic              io_out_0_ready;
  logic [BW-1:0]     io_out_0_bits_addr_beat;
  logic [25:0]       io_out_0_bits_addr_block;
  logic [5:0]        io_out_0_bits_client_xact_id;
  logic              io_out_0_bits_voluntary;
  logic [2:0]        io_out_0_bits_r_type;
  logic [DATA_W-1:0] io_out_0_bits_data;

  logic              io_out_1_valid;
  logic              io_out_1_ready;
  logic [BW-1:0]     io_out_1_bits_addr_beat;
  logic [25:0]       io_out_1_bits_addr_block;
  logic [5:0]        io_out_1_bits_client_xact_id;
  logic              io_out_1_bits_voluntary;
  logic [2:0]        io_out_1_bits_r_type;
  logic [DATA_W-1:0] io_out_1_bits_data;

  logic              io_chosen;
  logic              io_beat_err;

  modport master (
    output io_in_valid, io_in_bits_addr_beat, io_in_bits_addr_block,
           io_in_bits_client_xact_id, io_in_bits_voluntary, io_in_bits_r_type,
           io_in_bits_data, io_sel, io_out_0_ready, io_out_1_ready,
    input  io_in_ready, io_out_0_valid, io_out_0_bits_addr_beat,
           io_out_0_bits_addr_block, io_out_0_bits_client_xact_id,
           io_out_0_bits_voluntary, io_out_0_bits_r_type, io_out_0_bits_data,
           io_out_1_valid, io_out_1_bits_addr_beat, io_out_1_bits_addr_block,
           io_out_1_bits_client_xact_id, io_out_1_bits_voluntary,
           io_out_1_bits_r_type, io_out_1_bits_data, io_chosen, io_beat_err
  );

  modport slave (
    input  io_in_valid, io_in_bits_addr_beat, io_in_bits_addr_block,
           io_in_bits_client_xact_id, io_in_bits_voluntary, io_in_bits_r_type,
           io_in_bits_data, io_sel, io_out_0_ready, io_out_1_ready,
    output io_in_ready, io_out_0_valid, io_out_0_bits_addr_beat,
           io_out_0_bits_addr_block, io_out_0_bits_client_xact_id,
           io_out_0_bits_voluntary, io_out_0_bits_r_type, io_out_0_bits_data,
           io_out_1_valid, io_out_1_bits_addr_beat, io_out_1_bits_addr_block,
           io_out_1_bits_client_xact_id, io_out_1_bits_voluntary,
           io_out_1_bits_r_type, io_out_1_bits_data, io_chosen, io_beat_err
  );

endinterface

// File: rtl/locking_router_0_release_beat_counter.sv
// locking_router_0_release_beat_counter
//   Burst lock tracker. A data-carrying Release accepted while idle locks the
//   router to the selected output; every accepted beat while locked advances
//   a wrapping beat counter and the final beat releases the lock.
//   Ports:
//     clk, reset   - clock, asynchronous active-low reset
//     fire         - a beat was transferred this cycle
//     has_data     - the current beat is a data-carrying Release type
//     sel          - requested destination (captured when a burst opens)
//     locked       - a burst is in progress
//     lock_idx     - destination held for the burst
//     beat_cnt     - index of the next expected beat within the burst
module locking_router_0_release_beat_counter
  import locking_router_0_pkg::*;
#(
  parameter int N_BEATS = N_BEATS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fire,
  input  logic                       has_data,
  input  logic                       sel,
  output logic                       locked,
  output logic                       lock_idx,
  output logic [$clog2(N_BEATS)-1:0] beat_cnt
);

  localparam int CW = $clog2(N_BEATS);

  lock_state_e   state_q, state_d;
  logic          idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_beat;

  assign last_beat = (cnt_q == CW'(N_BEATS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOCK_IDLE;
      idx_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (fire) begin
      case (state_q)
        LOCK_IDLE: begin
          // Non-data beats are single-beat transfers and leave state alone.
          if (has_data) begin
            state_d = LOCK_HELD;
            idx_d   = sel;
            cnt_d   = CW'(1);
          end
        end
        LOCK_HELD: begin
          // Any beat mid-burst counts, whatever its r_type.
          if (last_beat) begin
            state_d = LOCK_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign locked   = (state_q == LOCK_HELD);
  assign lock_idx = idx_q;
  assign beat_cnt = cnt_q;

endmodule

// File: rtl/locking_router_0.sv
// locking_router_0
//   Steers one Release beat stream to one of two downstream Release sinks.
//   Data-carrying Releases lock the destination until the final beat, so a
//   burst is never split. Purely combinational data path, no buffering.
//   Ports:
//     clk, reset - clock, asynchronous active-low reset
//     bus        - locking_router_0_if.slave: upstream beat + io_sel, two
//                  downstream outputs, io_chosen, io_beat_err
//   Optional: define LOCKING_ROUTER_BEAT_CHECK_EN to build the sticky
//   addr_beat ordering checker driving io_beat_err (tied 0 otherwise).
module locking_router_0
  import locking_router_0_pkg::*;
#(
  parameter int N_BEATS = N_BEATS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  locking_router_0_if.slave    bus
);

  logic                       locked;
  logic                       lock_idx;
  logic [$clog2(N_BEATS)-1:0] beat_cnt;
  logic                       chosen;
  logic                       in_has_data;
  logic                       fire;

  assign in_has_data = has_data(bus.io_in_bits_r_type);

  // io_sel only matters while unlocked; a held burst ignores it.
  assign chosen          = locked ? lock_idx : bus.io_sel;
  assign bus.io_chosen   = chosen;
  assign bus.io_in_ready = chosen ? bus.io_out_1_ready : bus.io_out_0_ready;
  assign bus.io_out_0_valid = bus.io_in_valid & ~chosen;
  assign bus.io_out_1_valid = bus.io_in_valid &  chosen;
  assign fire = bus.io_in_valid & bus.io_in_ready;

  // Payload fans out to both sinks; only the valid is qualified.
  assign bus.io_out_0_bits_addr_beat      = bus.io_in_bits_addr_beat;
  assign bus.io_out_0_bits_addr_block     = bus.io_in_bits_addr_block;
  assign bus.io_out_0_bits_client_xact_id = bus.io_in_bits_client_xact_id;
  assign bus.io_out_0_bits_voluntary      = bus.io_in_bits_voluntary;
  assign bus.io_out_0_bits_r_type         = bus.io_in_bits_r_type;
  assign bus.io_out_0_bits_data           = bus.io_in_bits_data;
  assign bus.io_out_1_bits_addr_beat      = bus.io_in_bits_addr_beat;
  assign bus.io_out_1_bits_addr_block     = bus.io_in_bits_addr_block;
  assign bus.io_out_1_bits_client_xact_id = bus.io_in_bits_client_xact_id;
  assign bus.io_out_1_bits_voluntary      = bus.io_in_bits_voluntary;
  assign bus.io_out_1_bits_r_type         = bus.io_in_bits_r_type;
  assign bus.io_out_1_bits_data           = bus.io_in_bits_data;

  locking_router_0_release_beat_counter #(
    .N_BEATS (N_BEATS)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .fire     (fire),
    .has_data (in_has_data),
    .sel      (bus.io_sel),
    .locked   (locked),
    .lock_idx (lock_idx),
    .beat_cnt (beat_cnt)
  );

`ifdef LOCKING_ROUTER_BEAT_CHECK_EN
  logic                       beat_err_q;
  logic [$clog2(N_BEATS)-1:0] exp_beat;

  // A burst must open at beat 0 and then present beats in order.
  assign exp_beat = locked ? beat_cnt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_err_q <= 1'b0;
    end else if (fire && (in_has_data || locked) &&
                 (bus.io_in_bits_addr_beat != exp_beat)) begin
      beat_err_q <= 1'b1;
    end
  end

  assign bus.io_beat_err = beat_err_q;
`else
  // The beat count only feeds the ordering checker.
  logic unused_beat_cnt;
  assign unused_beat_cnt = ^beat_cnt;
  assign bus.io_beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_locking_router_0.sv
module tb_locking_router_0;
  import locking_router_0_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

`ifdef LOCKING_ROUTER_BEAT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  locking_router_0_if #(.N_BEATS(4), .DATA_W(128)) bus ();

  locking_router_0 #(.N_BEATS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [2:0] rt,
                       input logic [1:0] ab, input logic [127:0] d);
    release_beat_t b;
    b.addr_beat      = ab;
    b.addr_block     = 26'h2A5_5A5 ^ 26'(d[25:0]);
    b.client_xact_id = 6'h15;
    b.voluntary      = 1'b1;
    b.r_type         = rt;
    b.data           = d;
    bus.io_in_valid               = v;
    bus.io_sel                    = s;
    bus.io_in_bits_addr_beat      = b.addr_beat;
    bus.io_in_bits_addr_block     = b.addr_block;
    bus.io_in_bits_client_xact_id = b.client_xact_id;
    bus.io_in_bits_voluntary      = b.voluntary;
    bus.io_in_bits_r_type         = b.r_type;
    bus.io_in_bits_data           = b.data;
    #1;
  endtask

  function automatic logic [127:0] pat(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.io_out_0_ready = 1'b1;
    bus.io_out_1_ready = 1'b1;
    drive(1'b1, 1'b1, 3'd0, 2'd0, pat(0));
    tick();
    checks++; if (dut.u_cnt.locked !== 1'b0) begin failures++; $display("FAIL rst_locked actual=%0d expected=0", dut.u_cnt.locked); end
    checks++; if (dut.u_cnt.beat_cnt !== 2'd0) begin failures++; $display("FAIL rst_beat_cnt actual=%0d expected=0", dut.u_cnt.beat_cnt); end
    checks++; if (bus.io_chosen !== 1'b1) begin failures++; $display("FAIL rst_chosen actual=%0d expected=1", bus.io_chosen); end
    checks++; if (bus.io_out_1_valid !== 1'b1) begin failures++; $display("FAIL rst_out1_valid actual=%0d expected=1", bus.io_out_1_valid); end
    checks++; if (bus.io_out_0_valid !== 1'b0) begin failures++; $display("FAIL rst_out0_valid actual=%0d expected=0", bus.io_out_0_valid); end
    checks++; if (bus.io_beat_err !== 1'b0) begin failures++; $display("FAIL rst_beat_err actual=%0d expected=0", bus.io_beat_err); end
    drive(1'b0, 1'b0, 3'd3, 2'd0, pat(0));
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic test_non_data();
    drive(1'b1, 1'b1, 3'd3, 2'd0, pat(1));
    checks++; if (bus.io_out_1_valid !== 1'b1) begin failures++; $display("FAIL nd_out1_valid actual=%0d expected=1", bus.io_out_1_valid); end
    checks++; if (bus.io_out_0_valid !== 1'b0) begin failures++; $display("FAIL nd_out0_valid actual=%0d expected=0", bus.io_out_0_valid); end
    checks++; if (bus.io_in_ready !== 1'b1) begin failures++; $display("FAIL nd_in_ready actual=%0d expected=1", bus.io_in_ready); end
    tick();
    checks++; if (dut.u_cnt.locked !== 1'b0) begin failures++; $display("FAIL nd_locked actual=%0d expected=0", dut.u_cnt.locked); end
    checks++; if (dut.u_cnt.beat_cnt !== 2'd0) begin failures++; $display("FAIL nd_beat_cnt actual=%0d expected=0", dut.u_cnt.beat_cnt); end
    drive(1'b0, 1'b0, 3'd3, 2'd0, pat(1));
    tick();
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 1'b0 : 1'b1, 3'd0, 2'(i), pat(10 + i));
      checks++; if (bus.io_chosen !== 1'b0) begin failures++; $display("FAIL burst_chosen beat=%0d actual=%0d expected=0", i, bus.io_chosen); end
      checks++; if (bus.io_out_0_valid !== 1'b1 || bus.io_out_1_valid !== 1'b0) begin failures++; $display("FAIL burst_valids beat=%0d actual=%0d%0d expected=10", i, bus.io_out_0_valid, bus.io_out_1_valid); end
      checks++; if (bus.io_out_0_bits_data !== pat(10 + i) || bus.io_out_1_bits_data !== pat(10 + i)) begin failures++; $display("FAIL burst_data beat=%0d actual=%0h expected=%0h", i, bus.io_out_0_bits_data, pat(10 + i)); end
      checks++; if (dut.u_cnt.beat_cnt !== 2'(i)) begin failures++; $display("FAIL burst_beat_cnt beat=%0d actual=%0d expected=%0d", i, dut.u_cnt.beat_cnt, i); end
      tick();
    end
    checks++; if (dut.u_cnt.locked !== 1'b0) begin failures++; $display("FAIL burst_unlock actual=%0d expected=0", dut.u_cnt.locked); end
    drive(1'b1, 1'b1, 3'd3, 2'd0, pat(14));
    checks++; if (bus.io_chosen !== 1'b1 || bus.io_out_1_valid !== 1'b1) begin failures++; $display("FAIL burst_next_follows_sel actual=%0d%0d expected=11", bus.io_chosen, bus.io_out_1_valid); end
    tick();
    drive(1'b0, 1'b0, 3'd3, 2'd0, pat(0));
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 3'd1, 2'd0, pat(20));
    tick();
    bus.io_out_1_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 3'd1, 2'd1, pat(21));
      checks++; if (bus.io_in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d actual=%0d expected=0", c, bus.io_in_ready); end
      checks++; if (bus.io_out_0_valid !== 1'b0 || bus.io_out_1_valid !== 1'b1) begin failures++; $display("FAIL stall_valids cyc=%0d actual=%0d%0d expected=01", c, bus.io_out_0_valid, bus.io_out_1_valid); end
      tick();
      checks++; if (dut.u_cnt.beat_cnt !== 2'd1) begin failures++; $display("FAIL stall_beat_cnt cyc=%0d actual=%0d expected=1", c, dut.u_cnt.beat_cnt); end
    end
    bus.io_out_1_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'd1, 2'(i), pat(20 + i));
      checks++; if (bus.io_in_ready !== 1'b1 || bus.io_out_1_valid !== 1'b1) begin failures++; $display("FAIL stall_resume beat=%0d actual=%0d%0d expected=11", i, bus.io_in_ready, bus.io_out_1_valid); end
      tick();
    end
    checks++; if (dut.u_cnt.locked !== 1'b0) begin failures++; $display("FAIL stall_unlock actual=%0d expected=0", dut.u_cnt.locked); end
    drive(1'b0, 1'b0, 3'd3, 2'd0, pat(0));
  endtask

  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i < 4) ? 1'b0 : 1'b1, 3'd2, 2'(i % 4), pat(30 + i));
      if (i == 4) begin
        checks++; if (dut.u_cnt.beat_cnt !== 2'd0) begin failures++; $display("FAIL b2b_gap_beat_cnt actual=%0d expected=0", dut.u_cnt.beat_cnt); end
      end
      checks++; if (bus.io_chosen !== ((i < 4) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL b2b_chosen beat=%0d actual=%0d expected=%0d", i, bus.io_chosen, (i < 4) ? 0 : 1); end
      if (bus.io_in_valid && bus.io_in_ready && bus.io_out_0_valid) n0++;
      if (bus.io_in_valid && bus.io_in_ready && bus.io_out_1_valid) n1++;
      tick();
    end
    checks++; if (n0 !== 4) begin failures++; $display("FAIL b2b_out0_fires actual=%0d expected=4", n0); end
    checks++; if (n1 !== 4) begin failures++; $display("FAIL b2b_out1_fires actual=%0d expected=4", n1); end
    checks++; if (dut.u_cnt.beat_cnt !== 2'd0 || dut.u_cnt.locked !== 1'b0) begin failures++; $display("FAIL b2b_end_state actual=%0d/%0d expected=0/0", dut.u_cnt.locked, dut.u_cnt.beat_cnt); end
    drive(1'b0, 1'b0, 3'd3, 2'd0, pat(0));
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd0, 2'(i), pat(40 + i));
      tick();
    end
    checks++; if (dut.u_cnt.locked !== 1'b1 || dut.u_cnt.beat_cnt !== 2'd3) begin failures++; $display("FAIL mid_pre_reset actual=%0d/%0d expected=1/3", dut.u_cnt.locked, dut.u_cnt.beat_cnt); end
    drive(1'b0, 1'b1, 3'd3, 2'd0, pat(0));
    reset = 1'b0;
    #1;
    checks++; if (dut.u_cnt.locked !== 1'b0 || dut.u_cnt.beat_cnt !== 2'd0) begin failures++; $display("FAIL mid_reset_state actual=%0d/%0d expected=0/0", dut.u_cnt.locked, dut.u_cnt.beat_cnt); end
    #1 reset = 1'b1;
    drive(1'b1, 1'b1, 3'd3, 2'd3, pat(43));
    checks++; if (bus.io_chosen !== 1'b1 || bus.io_out_1_valid !== 1'b1 || bus.io_out_0_valid !== 1'b0) begin failures++; $display("FAIL mid_next_sel actual=%0d%0d%0d expected=110", bus.io_chosen, bus.io_out_1_valid, bus.io_out_0_valid); end
    tick();
    drive(1'b0, 1'b0, 3'd3, 2'd0, pat(0));
  endtask

  task automatic test_beat_check();
    logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd3, 2'd3};
    logic       exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'd0, seq[i], pat(50 + i));
      tick();
      checks++; if (bus.io_beat_err !== (CHK & exp[i])) begin failures++; $display("FAIL chk_err beat=%0d actual=%0d expected=%0d", i, bus.io_beat_err, CHK & exp[i]); end
    end
    drive(1'b0, 1'b0, 3'd3, 2'd0, pat(0));
    tick();
    checks++; if (bus.io_beat_err !== CHK) begin failures++; $display("FAIL chk_sticky actual=%0d expected=%0d", bus.io_beat_err, CHK); end
    reset = 1'b0;
    #1;
    checks++; if (bus.io_beat_err !== 1'b0) begin failures++; $display("FAIL chk_reset_clear actual=%0d expected=0", bus.io_beat_err); end
    #1 reset = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_non_data();
    test_burst();
    test_stall();
    test_back_to_back();
    test_reset_mid_burst();
    test_beat_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
